// File: rtl/score_pkg.sv
// Shared definitions for the score sequencer: state encoding, entry markers
// and helpers that pull the {pitch, duration} fields out of a ROM word.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  // Duration code that terminates a song, and pitch code that means silence.
  localparam int END_DUR    = 32'd0;
  localparam int REST_PITCH = 32'd0;

  // Low-order mask of w ones; saturates at a full 32-bit word.
  function automatic logic [31:0] field_mask(input int w);
    logic [31:0] mask;
    if (w >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << w) - 32'd1;
    end
    return mask;
  endfunction

  // Duration occupies the least-significant dur_w bits of an entry.
  function automatic logic [31:0] entry_dur(input logic [31:0] entry, input int dur_w);
    return entry & field_mask(dur_w);
  endfunction

  // Pitch sits directly above the duration field.
  function automatic logic [31:0] entry_pitch(input logic [31:0] entry,
                                              input int pitch_w,
                                              input int dur_w);
    return (entry >> dur_w) & field_mask(pitch_w);
  endfunction

endpackage

// File: rtl/score_sequencer.sv
// Walks a score ROM one eighth-note tick at a time and presents the current
// pitch downstream. Entries are {pitch, duration}; a zero duration ends the
// song. All outputs are registered.
module score_sequencer
  import score_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int PITCH_W = 6,
  parameter int DUR_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       eighth_note_enable,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [PITCH_W+DUR_W-1:0]   rom_data,
  output logic [PITCH_W-1:0]         note_pitch,
  output logic                       note_valid,
  output logic                       note_start,
  output logic                       song_done,
  output logic                       busy
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_END   = DUR_W'(END_DUR);
  localparam logic [PITCH_W-1:0] PITCH_REST = PITCH_W'(REST_PITCH);

  state_e               state_r, state_s;
  logic [ADDR_W-1:0]    addr_r, addr_s;
  logic [DUR_W-1:0]     dur_cnt_r, dur_cnt_s;
  logic                 tick_pend_r, tick_pend_s;
  logic [PITCH_W-1:0]   pitch_r, pitch_s;
  logic                 valid_r, valid_s;
  logic                 note_start_r, note_start_s;
  logic                 song_done_r, song_done_s;
  logic                 busy_r;

  logic [PITCH_W-1:0]   entry_pitch_s;
  logic [DUR_W-1:0]     entry_dur_s;
  logic                 eff_tick_s;

  // Split the ROM word into its fields and qualify the tick for PLAY.
  always_comb begin
    entry_pitch_s = PITCH_W'(entry_pitch(32'(rom_data), PITCH_W, DUR_W));
    entry_dur_s   = DUR_W'(entry_dur(32'(rom_data), DUR_W));
    eff_tick_s    = (eighth_note_enable | tick_pend_r) & ~pause;
  end

  // Next-state and next-output logic; start overrides everything else.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    dur_cnt_s    = dur_cnt_r;
    tick_pend_s  = tick_pend_r;
    pitch_s      = pitch_r;
    valid_s      = valid_r;
    note_start_s = 1'b0;
    song_done_s  = 1'b0;

    if (start) begin
      // Begin (or abort and restart) from the top of the score.
      state_s     = ST_FETCH;
      addr_s      = '0;
      dur_cnt_s   = '0;
      tick_pend_s = 1'b0;
      pitch_s     = '0;
      valid_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end

        ST_FETCH: begin
          // ROM address is presented this cycle; data appears in LOAD.
          state_s = ST_LOAD;
          if (eighth_note_enable) begin
            tick_pend_s = 1'b1;
          end else begin
            tick_pend_s = tick_pend_r;
          end
        end

        ST_LOAD: begin
          if (entry_dur_s == DUR_END) begin
            state_s     = ST_IDLE;
            song_done_s = 1'b1;
            pitch_s     = '0;
            valid_s     = 1'b0;
            tick_pend_s = 1'b0;
          end else begin
            state_s      = ST_PLAY;
            pitch_s      = entry_pitch_s;
            valid_s      = (entry_pitch_s != PITCH_REST);
            dur_cnt_s    = entry_dur_s;
            note_start_s = 1'b1;
            if (eighth_note_enable) begin
              tick_pend_s = 1'b1;
            end else begin
              tick_pend_s = tick_pend_r;
            end
          end
        end

        ST_PLAY: begin
          if (eff_tick_s) begin
            tick_pend_s = 1'b0;
            if (dur_cnt_r > DUR_ONE) begin
              dur_cnt_s = dur_cnt_r - DUR_ONE;
            end else if (addr_r == ADDR_LAST) begin
              // Score exhausted: finish rather than wrap the address.
              state_s     = ST_IDLE;
              dur_cnt_s   = '0;
              song_done_s = 1'b1;
              pitch_s     = '0;
              valid_s     = 1'b0;
            end else begin
              state_s   = ST_FETCH;
              dur_cnt_s = '0;
              addr_s    = addr_r + ADDR_ONE;
            end
          end else begin
            // Paused or no tick: everything holds, pending tick stays pending.
            state_s = ST_PLAY;
          end
        end

        default: begin
          state_s     = ST_IDLE;
          addr_s      = '0;
          dur_cnt_s   = '0;
          tick_pend_s = 1'b0;
          pitch_s     = '0;
          valid_s     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      dur_cnt_r    <= '0;
      tick_pend_r  <= 1'b0;
      pitch_r      <= '0;
      valid_r      <= 1'b0;
      note_start_r <= 1'b0;
      song_done_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      dur_cnt_r    <= dur_cnt_s;
      tick_pend_r  <= tick_pend_s;
      pitch_r      <= pitch_s;
      valid_r      <= valid_s;
      note_start_r <= note_start_s;
      song_done_r  <= song_done_s;
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign rom_addr   = addr_r;
  assign note_pitch = pitch_r;
  assign note_valid = valid_r;
  assign note_start = note_start_r;
  assign song_done  = song_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: two instances (8-bit and 2-bit address) share
// stimulus; a behavioural song model predicts every output each cycle, and
// directed scenarios pin absolute timings by hand.
module tb_score_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic ene = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] d8_rom_addr;
  logic [9:0] d8_rom_data;
  logic [5:0] d8_pitch;
  logic       d8_valid, d8_ns, d8_done, d8_busy;
  logic [1:0] d2_rom_addr;
  logic [9:0] d2_rom_data;
  logic [5:0] d2_pitch;
  logic       d2_valid, d2_ns, d2_done, d2_busy;

  logic [9:0] rom8 [0:255];
  logic [9:0] rom2 [0:3];

  score_sequencer #(.ADDR_W(8), .PITCH_W(6), .DUR_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause),
    .eighth_note_enable(ene), .rom_addr(d8_rom_addr), .rom_data(d8_rom_data),
    .note_pitch(d8_pitch), .note_valid(d8_valid), .note_start(d8_ns),
    .song_done(d8_done), .busy(d8_busy)
  );

  score_sequencer #(.ADDR_W(2), .PITCH_W(6), .DUR_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause),
    .eighth_note_enable(ene), .rom_addr(d2_rom_addr), .rom_data(d2_rom_data),
    .note_pitch(d2_pitch), .note_valid(d2_valid), .note_start(d2_ns),
    .song_done(d2_done), .busy(d2_busy)
  );

  // Synchronous score ROMs, one cycle of read latency.
  always @(posedge clk) begin
    d8_rom_data <= rom8[d8_rom_addr];
    d2_rom_data <= rom2[d2_rom_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_ctr = 0;
  int tick_period = 8;
  int tick_pct = 0;
  int t0 = 0;

  int ns8_t[$];
  int ns8_p[$];
  int done8_t[$];
  int ns2_t[$];
  int done2_t[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural song model ----------------
  // idx: score position; remain: ticks left on the note; fetch_left counts
  // the two ROM-access cycles before a new entry takes effect.
  typedef struct packed {
    int idx;
    int remain;
    int fetch_left;
    int pitch;
    bit pend;
    bit busy;
    bit valid;
    bit nstart;
    bit done;
  } mdl_t;

  mdl_t m8 = '0;
  mdl_t m2 = '0;

  function automatic mdl_t mdl_step(input mdl_t mi, input bit st, input bit pz, input bit tk,
                                    input int e_pitch, input int e_dur, input int last_idx);
    mdl_t m = mi;
    m.nstart = 1'b0;
    m.done = 1'b0;
    if (st) begin
      m.idx = 0; m.remain = 0; m.pend = 1'b0; m.pitch = 0; m.valid = 1'b0;
      m.fetch_left = 2; m.busy = 1'b1;
    end else if (m.fetch_left == 2) begin
      m.fetch_left = 1;
      if (tk) m.pend = 1'b1;
    end else if (m.fetch_left == 1) begin
      m.fetch_left = 0;
      if (e_dur == 0) begin
        m.done = 1'b1; m.pitch = 0; m.valid = 1'b0; m.busy = 1'b0; m.pend = 1'b0;
      end else begin
        m.pitch = e_pitch; m.valid = (e_pitch != 0); m.remain = e_dur; m.nstart = 1'b1;
        if (tk) m.pend = 1'b1;
      end
    end else if (m.busy && !pz && (tk || m.pend)) begin
      m.pend = 1'b0;
      if (m.remain > 1) begin
        m.remain = m.remain - 1;
      end else if (m.idx == last_idx) begin
        m.done = 1'b1; m.pitch = 0; m.valid = 1'b0; m.busy = 1'b0;
      end else begin
        m.idx = m.idx + 1;
        m.fetch_left = 2;
      end
    end
    return m;
  endfunction

  // Advance both models on every clock edge; reset is asynchronous.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m8 <= '0;
      m2 <= '0;
    end else begin
      m8 <= mdl_step(m8, start, pause, ene, int'(rom8[m8.idx][9:4]), int'(rom8[m8.idx][3:0]), 255);
      m2 <= mdl_step(m2, start, pause, ene, int'(rom2[m2.idx][9:4]), int'(rom2[m2.idx][3:0]), 3);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Compare every output of both instances with the model each cycle.
  always @(negedge clk) begin
    check("d8_pitch", 32'(d8_pitch), 32'(m8.pitch));
    check("d8_valid", 32'(d8_valid), 32'(m8.valid));
    check("d8_note_start", 32'(d8_ns), 32'(m8.nstart));
    check("d8_song_done", 32'(d8_done), 32'(m8.done));
    check("d8_busy", 32'(d8_busy), 32'(m8.busy));
    check("d8_rom_addr", 32'(d8_rom_addr), 32'(m8.idx));
    check("d2_pitch", 32'(d2_pitch), 32'(m2.pitch));
    check("d2_valid", 32'(d2_valid), 32'(m2.valid));
    check("d2_note_start", 32'(d2_ns), 32'(m2.nstart));
    check("d2_song_done", 32'(d2_done), 32'(m2.done));
    check("d2_busy", 32'(d2_busy), 32'(m2.busy));
    check("d2_rom_addr", 32'(d2_rom_addr), 32'(m2.idx));
  end

  // Event log used by the hand-computed timing checks.
  always @(negedge clk) begin
    if (d8_ns) begin
      ns8_t.push_back(cyc);
      ns8_p.push_back(int'(d8_pitch));
    end
    if (d8_done) done8_t.push_back(cyc);
    if (d2_ns) ns2_t.push_back(cyc);
    if (d2_done) done2_t.push_back(cyc);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [9:0] ent(input int p, input int d);
    logic [5:0] pp;
    logic [3:0] dd;
    pp = 6'(p);
    dd = 4'(d);
    return {pp, dd};
  endfunction

  task automatic tick_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      tick_ctr++;
      if (tick_period > 0) ene = ((tick_ctr % tick_period) == 0);
      else ene = (int'($urandom_range(0, 99)) < tick_pct);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    ene = 1'b0;
    tick_ctr = 0;
    t0 = cyc;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    ene = 1'b0;
    for (int i = 0; i < 256; i++) rom8[i] = ent(0, 0);
    for (int i = 0; i < 4; i++) rom2[i] = ent(1, 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    ns8_t.delete(); ns8_p.delete(); done8_t.delete();
    ns2_t.delete(); done2_t.delete();
  endtask

  initial begin
    #3 reset_n = 1'b0;
    hold_reset();
    @(negedge clk);
    check("rst_busy", 32'(d8_busy), 32'd0);
    check("rst_pitch", 32'(d8_pitch), 32'd0);
    check("rst_addr", 32'(d8_rom_addr), 32'd0);

    // 1: two notes then end marker, tick every 8 cycles.
    rom8[0] = ent(5, 2); rom8[1] = ent(9, 1); rom8[2] = ent(0, 0);
    release_reset();
    tick_period = 8;
    pulse_start();
    tick_cycles(40);
    check("t1_ns_count", 32'(ns8_t.size()), 32'd2);
    check("t1_ns0_time", 32'(ns8_t[0] - t0), 32'd3);
    check("t1_ns0_pitch", 32'(ns8_p[0]), 32'd5);
    check("t1_ns1_time", 32'(ns8_t[1] - t0), 32'd19);
    check("t1_ns1_pitch", 32'(ns8_p[1]), 32'd9);
    check("t1_done_count", 32'(done8_t.size()), 32'd1);
    check("t1_done_time", 32'(done8_t[0] - t0), 32'd27);
    check("t1_busy_end", 32'(d8_busy), 32'd0);

    // 2: rest entry of three ticks.
    hold_reset();
    rom8[0] = ent(0, 3);
    release_reset();
    pulse_start();
    tick_cycles(10);
    check("t2_busy", 32'(d8_busy), 32'd1);
    check("t2_valid", 32'(d8_valid), 32'd0);
    tick_cycles(30);
    check("t2_ns_count", 32'(ns8_t.size()), 32'd1);
    check("t2_done_time", 32'(done8_t[0] - t0), 32'd27);

    // 3: tick during LOAD is held and ends a one-tick note at once.
    hold_reset();
    rom8[0] = ent(7, 1);
    release_reset();
    tick_period = 0;
    tick_pct = 0;
    pulse_start();
    tick_cycles(1);
    @(negedge clk);
    ene = 1'b1;
    tick_cycles(3);
    check("t3_pitch_held", 32'(d8_pitch), 32'd7);
    check("t3_valid_held", 32'(d8_valid), 32'd1);
    tick_cycles(10);
    check("t3_done_time", 32'(done8_t[0] - t0), 32'd6);

    // 4: pause masks two ticks during a four-tick note.
    hold_reset();
    rom8[0] = ent(3, 4);
    release_reset();
    tick_period = 8;
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      tick_cycles(1);
      pause = (i >= 10 && i < 30);
    end
    pause = 1'b0;
    check("t4_done_time", 32'(done8_t[0] - t0), 32'd51);

    // 5: restart mid-note at address 3.
    hold_reset();
    rom8[0] = ent(1, 1); rom8[1] = ent(2, 1); rom8[2] = ent(3, 1); rom8[3] = ent(4, 8);
    release_reset();
    pulse_start();
    tick_cycles(30);
    check("t5_addr3", 32'(d8_rom_addr), 32'd3);
    check("t5_pitch4", 32'(d8_pitch), 32'd4);
    pulse_start();
    tick_cycles(1);
    check("t5_addr0", 32'(d8_rom_addr), 32'd0);
    check("t5_pitch_clr", 32'(d8_pitch), 32'd0);
    tick_cycles(2);
    check("t5_ns", 32'(d8_ns), 32'd1);
    check("t5_pitch1", 32'(d8_pitch), 32'd1);
    check("t5_no_done", 32'(done8_t.size()), 32'd0);
    tick_cycles(3);

    // 6: asynchronous reset between edges mid-note, then replay.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(d8_busy), 32'd0);
    check("t6_pitch", 32'(d8_pitch), 32'd0);
    check("t6_valid", 32'(d8_valid), 32'd0);
    check("t6_addr", 32'(d8_rom_addr), 32'd0);
    ene = 1'b0;
    @(negedge clk);
    release_reset();
    pulse_start();
    tick_cycles(4);
    check("t6_replay_time", 32'(ns8_t[0] - t0), 32'd3);
    check("t6_replay_pitch", 32'(ns8_p[0]), 32'd1);

    // 7: 2-bit address, four notes, no wrap.
    hold_reset();
    rom2[0] = ent(1, 1); rom2[1] = ent(2, 1); rom2[2] = ent(3, 1); rom2[3] = ent(4, 1);
    release_reset();
    pulse_start();
    tick_cycles(45);
    check("t7_ns_count", 32'(ns2_t.size()), 32'd4);
    check("t7_done_time", 32'(done2_t[0] - t0), 32'd33);
    check("t7_done_count", 32'(done2_t.size()), 32'd1);
    check("t7_addr_nowrap", 32'(d2_rom_addr), 32'd3);
    check("t7_busy", 32'(d2_busy), 32'd0);

    // Randomised phase: random scores, ticks, pauses and restarts.
    hold_reset();
    for (int i = 0; i < 256; i++) begin
      rom8[i] = ent(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63)),
                    ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 4; i++) rom2[i] = ent(int'($urandom_range(0, 63)), int'($urandom_range(1, 3)));
    release_reset();
    tick_period = 0;
    tick_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      tick_cycles(1);
      pause = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 49) == 0);
    end
    tick_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
